// File: rtl/seq_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : seq_shift_unit
// Desc     : Multi-cycle 32-bit SHL/SHR/ROR/ROL unit with start/busy/done
//            handshake. Define SHIFT_STEP4_EN to move up to 4 positions/cycle.
// Revision : 1.0 - initial release
// ============================================================================
module seq_shift_unit #(
    parameter int WIDTH = 32,
    parameter int NW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src_i,
    input  logic [NW-1:0]    n_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [1:0] c_op_shl = 2'b00;
    localparam logic [1:0] c_op_shr = 2'b01;
    localparam logic [1:0] c_op_ror = 2'b10;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [1:0]       r_op;
    logic [NW-1:0]    r_cnt;
    logic             r_carry;

    logic [WIDTH-1:0] w_acc;
    logic             w_carry;
    logic [NW-1:0]    w_step;
    logic [NW-1:0]    w_cnt;

    // One-position move; returns {bit shifted out, new accumulator}.
    function automatic logic [WIDTH:0] shift1(input logic [WIDTH-1:0] acc,
                                              input logic [1:0] op);
        logic [WIDTH:0] res;
        case (op)
            c_op_shl: res = {acc[WIDTH-1], acc[WIDTH-2:0], 1'b0};
            c_op_shr: res = {acc[0], 1'b0, acc[WIDTH-1:1]};
            c_op_ror: res = {acc[0], acc[0], acc[WIDTH-1:1]};
            default:  res = {acc[WIDTH-1], acc[WIDTH-2:0], acc[WIDTH-1]};
        endcase
        return res;
    endfunction

    always_comb begin
        w_acc   = r_acc;
        w_carry = r_carry;
`ifdef SHIFT_STEP4_EN
        w_step = (r_cnt >= NW'(4)) ? NW'(4) : r_cnt;
        for (int i = 0; i < 4; i++) begin
            if (NW'(i) < w_step) begin
                {w_carry, w_acc} = shift1(w_acc, r_op);
            end
        end
`else
        w_step = NW'(1);
        {w_carry, w_acc} = shift1(r_acc, r_op);
`endif
        w_cnt = r_cnt - w_step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_acc    <= '0;
            r_op     <= 2'b00;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
            carry_o  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        r_acc   <= src_i;
                        r_op    <= op_i;
                        r_cnt   <= n_i;
                        r_carry <= 1'b0;
                        busy_o  <= 1'b1;
                        r_state <= c_st_run;
                    end else begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_run: begin
                    if (r_cnt != '0) begin
                        r_acc   <= w_acc;
                        r_carry <= w_carry;
                        r_cnt   <= w_cnt;
                    end else begin
                        result_o <= r_acc;
                        carry_o  <= r_carry;
                        done_o   <= 1'b1;
                        busy_o   <= 1'b0;
                        r_state  <= c_st_done;
                    end
                end
                default: begin
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/seq_shift_unit.md
# seq_shift_unit

Multi-cycle 32-bit shift/rotate execution unit for the ALU datapath. It accepts a start request with a source word, an operation and a shift amount, and shifts one bit position per clock. It reports busy, pulses done, and holds the result together with the last bit shifted out. The carry output feeds the S-bit/CMP flag logic. It complements the combinational shift_left, shift_right and rotate_right units: it adds rotate-left and a sequential, handshaked path that the control unit can stall on.

## Interface
- WIDTH, 32, datapath width in bits
- NW, 5, shift-amount width; must equal log2(WIDTH)

- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous and active-low
- start_i  input  1  request; sampled on a clk edge only when busy_o=0
- op_i  input  2  operation: 00 SHL logical, 01 SHR logical, 10 ROR, 11 ROL
- src_i  input  WIDTH  operand; captured on the accepted start
- n_i  input  NW  shift amount 0..31; captured on the accepted start
- busy_o  output  1  operation in progress
- done_o  output  1  one-cycle pulse; result_o and carry_o are valid and updated
- result_o  output  WIDTH  result; held until the next done
- carry_o  output  1  last bit shifted or rotated out; 0 when the amount is 0

## Operation
- Reset values: busy_o=0, done_o=0, result_o=0, carry_o=0, FSM in IDLE.
- FSM states and transitions:
  - IDLE: on start_i=1, capture src_i into the accumulator, op_i and n_i into the counter, then go to RUN.
  - RUN: if the counter is not 0, shift the accumulator one position, update the internal carry, decrement the counter and stay in RUN. If the counter is 0, write the accumulator to result_o and the internal carry to carry_o, then go to DONE.
  - DONE: done_o=1 for this single cycle. If start_i=1, accept the new request exactly as IDLE does and go to RUN. Otherwise go to IDLE.
- busy_o=1 only in RUN.
- Per-step behaviour, with acc as the accumulator:
  - SHL: carry=acc[31]; acc={acc[30:0],0}.
  - SHR: carry=acc[0]; acc={0,acc[31:1]}.
  - ROR: carry=acc[0]; acc={acc[0],acc[31:1]}.
  - ROL: carry=acc[31]; acc={acc[30:0],acc[31]}.
- The internal carry is cleared on capture, so an amount of 0 gives result=src and carry=0.
- start_i while busy_o=1 is ignored. It is not queued, and the in-flight operation is unaffected.
- src_i, op_i and n_i changing after capture have no effect.
- An amount of 32 is not representable; n_i[4:0] alone is used.
- rst_n low at any time, including mid-RUN: all outputs and state return to reset values immediately. The operation is abandoned and no done pulse is produced.

## Timing
- An accepted start on edge E gives done_o high for the cycle after edge E+n+1. result_o and carry_o update on that same edge.
- Latency examples: n=0 → done after edge E+1; n=31 → done after edge E+32.
- Back-to-back: a start on the edge that ends DONE is accepted, with no IDLE gap.
- Outputs are all registered; there is no combinational path from inputs to outputs.

## Configuration
- SHIFT_STEP4_EN defined: each RUN cycle shifts min(4, counter) positions, and the counter decrements by that step. carry_o is the last bit out of the final step. Done latency becomes ceil(n/4)+1 edges after the start edge.
- SHIFT_STEP4_EN undefined: one position per cycle, as specified above.
- Results and carry are identical in both builds; only the latency differs.

## Test plan
- SHL, src FFFFFFFF, n=1 → result FFFFFFFE, carry 1, done after edge E+2; busy high for exactly 2 cycles.
- SHR, src FFFFFFFF, n=31 → result 00000001, carry 1. Done after edge E+32, or E+9 with SHIFT_STEP4_EN.
- ROR, src FFFF0000, n=1 → 7FFF8000, carry 0. Then back-to-back start in the DONE cycle with ROR, src 0000FFFF, n=1 → 80007FFF, carry 1, with no idle cycle between.
- ROL, src 80000001, n=4 → 00000018, carry 0. SHL, src 12345678, n=0 → 12345678, carry 0, done after edge E+1.
- Second start with src AAAAAAAA while busy → ignored; the first result is unchanged and only one done pulse occurs.
- rst_n low mid-run → busy_o, done_o, result_o and carry_o go to 0 asynchronously. No done occurs until a fresh start after release.
